// File: rtl/sddac_adder_seq_if.sv
// Sample handshake, modulator outputs and shared-adder bus of the sigma-delta controller.
// master is the controller side; slave is the sample source / adder / DAC side.
interface sddac_adder_seq_if #(
    parameter int unsigned DW = 24
);
    logic          smp_valid;
    logic          smp_ready;
    logic [DW-1:0] smp_l;
    logic [DW-1:0] smp_r;
    logic          dac_l;
    logic          dac_r;
    logic          done;
    logic          adder_reset;
    logic [8:0]    adder_opmode;
    logic [47:0]   adder_dabin;
    logic [47:0]   adder_cin;
    logic [47:0]   adder_pout;

    modport master (
        input  smp_valid, smp_l, smp_r, adder_pout,
        output smp_ready, dac_l, dac_r, done,
        output adder_reset, adder_opmode, adder_dabin, adder_cin
    );

    modport slave (
        output smp_valid, smp_l, smp_r, adder_pout,
        input  smp_ready, dac_l, dac_r, done,
        input  adder_reset, adder_opmode, adder_dabin, adder_cin
    );
endinterface

// File: rtl/sddac_adder_seq.sv
// Two-channel second-order sigma-delta modulator that time-shares one external
// registered 48-bit add/sub unit; one sample pair is processed every 10 cycles.
module sddac_adder_seq #(
    parameter int unsigned        DW = 24,
    parameter logic signed [47:0] FB = 48'sd1 <<< (DW - 1)
) (
    input logic               clk,
    input logic               reset,
    sddac_adder_seq_if.master sd_if
);
    localparam logic [8:0] OpIdle = 9'h000;
    localparam logic [8:0] OpAdd  = 9'h00F;
    localparam logic [8:0] OpSub  = 9'h08F;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [3:0]         step_q, step_d;
    logic signed [47:0] xl_q, xl_d, xr_q, xr_d;
    logic signed [47:0] i1_l_q, i1_l_d, i1_r_q, i1_r_d;
    logic signed [47:0] i2_l_q, i2_l_d, i2_r_q, i2_r_d;
    logic signed [47:0] tl_q, tl_d, tr_q, tr_d;
    logic               dac_l_q, dac_l_d, dac_r_q, dac_r_d;
    logic               done_q, done_d;
    logic               adder_reset_q;
    logic [8:0]         opmode;
    logic [47:0]        cin, dab;

    // A set dac bit means the output was high, so the feedback is subtracted.
    function automatic logic [8:0] fb_op(input logic dac);
        return dac ? OpSub : OpAdd;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            step_q        <= '0;
            xl_q          <= '0;
            xr_q          <= '0;
            i1_l_q        <= '0;
            i1_r_q        <= '0;
            i2_l_q        <= '0;
            i2_r_q        <= '0;
            tl_q          <= '0;
            tr_q          <= '0;
            dac_l_q       <= 1'b0;
            dac_r_q       <= 1'b0;
            done_q        <= 1'b0;
            adder_reset_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            xl_q          <= xl_d;
            xr_q          <= xr_d;
            i1_l_q        <= i1_l_d;
            i1_r_q        <= i1_r_d;
            i2_l_q        <= i2_l_d;
            i2_r_q        <= i2_r_d;
            tl_q          <= tl_d;
            tr_q          <= tr_d;
            dac_l_q       <= dac_l_d;
            dac_r_q       <= dac_r_d;
            done_q        <= done_d;
            adder_reset_q <= 1'b0;
        end
    end

    // Adder operands depend on registered state only; pout carries the previous step's result.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        xl_d    = xl_q;
        xr_d    = xr_q;
        i1_l_d  = i1_l_q;
        i1_r_d  = i1_r_q;
        i2_l_d  = i2_l_q;
        i2_r_d  = i2_r_q;
        tl_d    = tl_q;
        tr_d    = tr_q;
        dac_l_d = dac_l_q;
        dac_r_d = dac_r_q;
        done_d  = 1'b0;
        opmode  = OpIdle;
        cin     = '0;
        dab     = '0;

        unique case (state_q)
            StIdle: begin
                if (sd_if.smp_valid) begin
                    xl_d    = {{(48 - DW){sd_if.smp_l[DW-1]}}, sd_if.smp_l};
                    xr_d    = {{(48 - DW){sd_if.smp_r[DW-1]}}, sd_if.smp_r};
                    state_d = StRun;
                    step_d  = '0;
                end
            end
            StRun: begin
                step_d = step_q + 4'd1;
                case (step_q)
                    4'd0: begin
                        opmode = OpAdd;
                        cin    = i1_l_q;
                        dab    = xl_q;
                    end
                    4'd1: begin
                        opmode = OpAdd;
                        cin    = i1_r_q;
                        dab    = xr_q;
                        tl_d   = sd_if.adder_pout;
                    end
                    4'd2: begin
                        opmode = fb_op(dac_l_q);
                        cin    = tl_q;
                        dab    = FB;
                        tr_d   = sd_if.adder_pout;
                    end
                    4'd3: begin
                        opmode = fb_op(dac_r_q);
                        cin    = tr_q;
                        dab    = FB;
                        i1_l_d = sd_if.adder_pout;
                    end
                    4'd4: begin
                        opmode = OpAdd;
                        cin    = i2_l_q;
                        dab    = i1_l_q;
                        i1_r_d = sd_if.adder_pout;
                    end
                    4'd5: begin
                        opmode = OpAdd;
                        cin    = i2_r_q;
                        dab    = i1_r_q;
                        tl_d   = sd_if.adder_pout;
                    end
                    4'd6: begin
                        opmode = fb_op(dac_l_q);
                        cin    = tl_q;
                        dab    = FB;
                        tr_d   = sd_if.adder_pout;
                    end
                    4'd7: begin
                        opmode = fb_op(dac_r_q);
                        cin    = tr_q;
                        dab    = FB;
                        i2_l_d = sd_if.adder_pout;
                    end
                    4'd8: begin
                        i2_r_d  = sd_if.adder_pout;
                        dac_l_d = ~i2_l_q[47];
                        dac_r_d = ~sd_if.adder_pout[47];
                        done_d  = 1'b1;
                        state_d = StIdle;
                        step_d  = '0;
                    end
                    default: begin
                        state_d = StIdle;
                        step_d  = '0;
                    end
                endcase
            end
            default: state_d = StIdle;
        endcase
    end

    assign sd_if.smp_ready    = (state_q == StIdle);
    assign sd_if.dac_l        = dac_l_q;
    assign sd_if.dac_r        = dac_r_q;
    assign sd_if.done         = done_q;
    assign sd_if.adder_reset  = adder_reset_q;
    assign sd_if.adder_opmode = opmode;
    assign sd_if.adder_cin    = cin;
    assign sd_if.adder_dabin  = dab;
endmodule

// File: tb/tb_sddac_adder_seq.sv
// Bench for sddac_adder_seq: models the registered DSP adder and checks every step's
// adder operands plus the dac bits against an arithmetic second-order modulator model.
module tb_sddac_adder_seq;
    localparam logic signed [47:0] FB     = 48'sd8388608;
    localparam logic [8:0]         OP_ADD = 9'h00F;
    localparam logic [8:0]         OP_SUB = 9'h08F;

    typedef struct packed {
        logic [8:0]  op;
        logic [47:0] c;
        logic [47:0] d;
    } step_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   ntotal = 0;
    int   npass = 0;
    int   nfail = 0;

    step_t              exp_tr [9];
    logic signed [47:0] m_i1l, m_i1r, m_i2l, m_i2r;
    logic               m_dl, m_dr;

    sddac_adder_seq_if #(.DW(24)) sd_if ();

    sddac_adder_seq #(.DW(24)) dut (
        .clk   (clk),
        .reset (reset),
        .sd_if (sd_if)
    );

    always #5 clk = ~clk;

    // Registered DSP adder: P = C +/- DAB one cycle later, synchronous clear.
    always @(posedge clk) begin
        if (sd_if.adder_reset) sd_if.adder_pout <= '0;
        else begin
            case (sd_if.adder_opmode)
                OP_ADD:  sd_if.adder_pout <= sd_if.adder_cin + sd_if.adder_dabin;
                OP_SUB:  sd_if.adder_pout <= sd_if.adder_cin - sd_if.adder_dabin;
                default: sd_if.adder_pout <= '0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        ntotal++;
        assert (obs === expv) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [8:0] fb_op(input logic d);
        return d ? OP_SUB : OP_ADD;
    endfunction

    task automatic model_reset();
        m_i1l = '0; m_i1r = '0; m_i2l = '0; m_i2r = '0;
        m_dl = 1'b0; m_dr = 1'b0;
    endtask

    // i1 += x -/+ FB, i2 += i1 -/+ FB, dac = (i2 >= 0); also the expected adder trace.
    task automatic model_sample(input logic signed [47:0] xl, input logic signed [47:0] xr);
        logic signed [47:0] al, ar, n1l, n1r, bl, br, n2l, n2r;
        al  = m_i1l + xl;
        ar  = m_i1r + xr;
        n1l = m_dl ? al - FB : al + FB;
        n1r = m_dr ? ar - FB : ar + FB;
        bl  = m_i2l + n1l;
        br  = m_i2r + n1r;
        n2l = m_dl ? bl - FB : bl + FB;
        n2r = m_dr ? br - FB : br + FB;
        exp_tr[0] = '{op: OP_ADD, c: m_i1l, d: xl};
        exp_tr[1] = '{op: OP_ADD, c: m_i1r, d: xr};
        exp_tr[2] = '{op: fb_op(m_dl), c: al, d: FB};
        exp_tr[3] = '{op: fb_op(m_dr), c: ar, d: FB};
        exp_tr[4] = '{op: OP_ADD, c: m_i2l, d: n1l};
        exp_tr[5] = '{op: OP_ADD, c: m_i2r, d: n1r};
        exp_tr[6] = '{op: fb_op(m_dl), c: bl, d: FB};
        exp_tr[7] = '{op: fb_op(m_dr), c: br, d: FB};
        exp_tr[8] = '{op: 9'h000, c: 48'h0, d: 48'h0};
        m_i1l = n1l; m_i1r = n1r; m_i2l = n2l; m_i2r = n2r;
        m_dl = (n2l >= 0);
        m_dr = (n2r >= 0);
    endtask

    function automatic logic signed [23:0] rnd_smp();
        int v;
        v = int'($urandom_range(16777214)) - 8388607;
        return 24'(v);
    endfunction

    // Called at a negedge; returns at the negedge of cycle T+10. With hold, valid stays
    // high and junk data is presented during the busy cycles.
    task automatic run_sample(input logic signed [23:0] l, input logic signed [23:0] r,
                              input bit hold);
        int n;
        n = 0;
        while (sd_if.smp_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready before accept", 48'(sd_if.smp_ready), 48'h1);
        sd_if.smp_valid = 1'b1;
        sd_if.smp_l     = l;
        sd_if.smp_r     = r;
        model_sample(48'(l), 48'(r));
        @(posedge clk);
        @(negedge clk);
        if (!hold) sd_if.smp_valid = 1'b0;
        for (int s = 0; s < 9; s++) begin
            chk($sformatf("s%0d opmode", s), 48'(sd_if.adder_opmode), 48'(exp_tr[s].op));
            chk($sformatf("s%0d cin", s), sd_if.adder_cin, exp_tr[s].c);
            chk($sformatf("s%0d dabin", s), sd_if.adder_dabin, exp_tr[s].d);
            chk($sformatf("s%0d ready", s), 48'(sd_if.smp_ready), 48'h0);
            chk($sformatf("s%0d done", s), 48'(sd_if.done), 48'h0);
            if (hold) begin
                sd_if.smp_l = rnd_smp();
                sd_if.smp_r = rnd_smp();
            end
            @(negedge clk);
        end
        chk("done pulse", 48'(sd_if.done), 48'h1);
        chk("dac_l", 48'(sd_if.dac_l), 48'(m_dl));
        chk("dac_r", 48'(sd_if.dac_r), 48'(m_dr));
        chk("ready after run", 48'(sd_if.smp_ready), 48'h1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst ready", 48'(sd_if.smp_ready), 48'h1);
        chk("rst done", 48'(sd_if.done), 48'h0);
        chk("rst dac_l", 48'(sd_if.dac_l), 48'h0);
        chk("rst dac_r", 48'(sd_if.dac_r), 48'h0);
        chk("rst opmode", 48'(sd_if.adder_opmode), 48'h0);
        chk("rst cin", sd_if.adder_cin, 48'h0);
        chk("rst dabin", sd_if.adder_dabin, 48'h0);
        chk("rst adder_reset", 48'(sd_if.adder_reset), 48'h1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_outputs();
        @(posedge clk);
        @(negedge clk);
        chk("adder_reset one cycle", 48'(sd_if.adder_reset), 48'h0);
        chk("post-reset ready", 48'(sd_if.smp_ready), 48'h1);
        model_reset();
    endtask

    initial begin
        int ones_l, ones_r;
        sd_if.smp_valid = 1'b0;
        sd_if.smp_l     = '0;
        sd_if.smp_r     = '0;
        repeat (3) @(negedge clk);
        release_reset();

        // Zero input from reset: three hand-checked samples.
        run_sample(24'sd0, 24'sd0, 1'b0);
        chk("zero s1 dac_l", 48'(sd_if.dac_l), 48'h1);
        run_sample(24'sd0, 24'sd0, 1'b0);
        chk("zero s2 dac_r", 48'(sd_if.dac_r), 48'h1);
        run_sample(24'sd0, 24'sd0, 1'b0);
        chk("zero s3 dac_l", 48'(sd_if.dac_l), 48'h0);
        chk("zero s3 dac_r", 48'(sd_if.dac_r), 48'h0);

        // Half-scale constants from a fresh reset: ones densities 3/4 and 1/4.
        reset = 1'b0;
        release_reset();
        ones_l = 0;
        ones_r = 0;
        for (int k = 0; k < 64; k++) begin
            run_sample(24'sd4194304, -24'sd4194304, 1'b0);
            ones_l += int'(sd_if.dac_l);
            ones_r += int'(sd_if.dac_r);
        end
        chk("L ones in 47..49", 48'(ones_l >= 47 && ones_l <= 49), 48'h1);
        chk("R ones in 15..17", 48'(ones_r >= 15 && ones_r <= 17), 48'h1);

        // smp_valid held high with changing data: only the accepted pairs matter.
        for (int k = 0; k < 10; k++) run_sample(rnd_smp(), rnd_smp(), 1'b1);
        sd_if.smp_valid = 1'b0;

        // Reset during s4 aborts without a clock edge.
        @(negedge clk);
        sd_if.smp_valid = 1'b1;
        sd_if.smp_l     = rnd_smp();
        sd_if.smp_r     = rnd_smp();
        @(posedge clk);
        @(negedge clk);
        sd_if.smp_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-abort opmode s4", 48'(sd_if.adder_opmode), 48'(OP_ADD));
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs();
        release_reset();
        run_sample(24'sd0, 24'sd0, 1'b0);
        chk("after abort dac_l", 48'(sd_if.dac_l), 48'h1);
        chk("after abort dac_r", 48'(sd_if.dac_r), 48'h1);

        // Random sample pairs, back to back.
        for (int k = 0; k < 1000; k++) run_sample(rnd_smp(), rnd_smp(), 1'b0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
